// File: rtl/ni_tdm_out_queue.sv
// TDM endpoint transmit queue: buffers core flits and sends each one on both redundant links
// in granted slots, inserting running-count checkpoints every MAX_LEN data flits and on idle.
module ni_tdm_out_queue #(
  parameter int FLIT_WIDTH = 32,
  parameter int CT_LINKS   = 2,
  parameter int DEPTH      = 16,
  parameter int MAX_LEN    = 8,
  localparam int CNT_WIDTH  = 16,
  localparam int FILL_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                                clk_noc,
  input  logic                                rst_noc_n,
  input  logic [FLIT_WIDTH-1:0]               in_flit,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [FILL_WIDTH-1:0]               num_free,
  input  logic                                slot_en,
  input  logic [CT_LINKS-1:0]                 link_en,
  input  logic                                force_cp,
  output logic [CT_LINKS-1:0][FLIT_WIDTH-1:0] out_flit,
  output logic [CT_LINKS-1:0]                 out_valid,
  output logic [CT_LINKS-1:0]                 out_checkpoint
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int SINCE_W = $clog2(MAX_LEN + 1);

  if (CT_LINKS != 2) begin : g_links_check
    $fatal(1, "ni_tdm_out_queue supports only CT_LINKS == 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $fatal(1, "ni_tdm_out_queue requires DEPTH to be a power of 2");
  end

  logic [FLIT_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [FILL_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0]  flit_cnt_r;
  logic [SINCE_W-1:0]    since_cp_r;
  logic                  cp_pending_r;

  logic push_s;
  logic empty_s;
  logic cp_due_s;
  logic send_cp_s;
  logic send_data_s;

  assign in_ready = (count_r != FILL_WIDTH'(DEPTH));
  assign num_free = FILL_WIDTH'(DEPTH) - count_r;

  // Slot arbitration: forced/overdue checkpoint, then data, then idle flush.
  always_comb begin
    empty_s     = (count_r == '0);
    cp_due_s    = cp_pending_r | force_cp | (since_cp_r == SINCE_W'(MAX_LEN));
    push_s      = in_valid & in_ready;
    send_cp_s   = 1'b0;
    send_data_s = 1'b0;
    if (slot_en) begin
      if (cp_due_s) begin
        send_cp_s = 1'b1;
      end else if (!empty_s) begin
        send_data_s = 1'b1;
      end else if (since_cp_r != '0) begin
        send_cp_s = 1'b1;
      end else begin
        send_cp_s = 1'b0;
      end
    end else begin
      send_data_s = 1'b0;
    end
  end

  // Flit storage; reset only clears the pointers, so stale entries are simply unreachable.
  always_ff @(posedge clk_noc) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_flit;
    end
  end

  // Buffer pointers, fill count and checkpoint bookkeeping.
  always_ff @(posedge clk_noc or negedge rst_noc_n) begin
    if (!rst_noc_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      flit_cnt_r   <= '0;
      since_cp_r   <= '0;
      cp_pending_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (send_data_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
        flit_cnt_r <= flit_cnt_r + CNT_WIDTH'(1);
        since_cp_r <= since_cp_r + SINCE_W'(1);
      end else if (send_cp_s) begin
        since_cp_r <= '0;
      end
      case ({push_s, send_data_s})
        2'b10:   count_r <= count_r + FILL_WIDTH'(1);
        2'b01:   count_r <= count_r - FILL_WIDTH'(1);
        default: count_r <= count_r;
      endcase
      if (send_cp_s) begin
        cp_pending_r <= 1'b0;
      end else if (force_cp) begin
        cp_pending_r <= 1'b1;
      end
    end
  end

  // Registered link outputs; flit/checkpoint hold when nothing is sent.
  always_ff @(posedge clk_noc or negedge rst_noc_n) begin
    if (!rst_noc_n) begin
      out_flit       <= '0;
      out_valid      <= '0;
      out_checkpoint <= '0;
    end else begin
      out_valid <= (send_cp_s | send_data_s) ? link_en : '0;
      if (send_cp_s) begin
        out_flit       <= {CT_LINKS{FLIT_WIDTH'(flit_cnt_r)}};
        out_checkpoint <= '1;
      end else if (send_data_s) begin
        out_flit       <= {CT_LINKS{mem_r[rd_ptr_r]}};
        out_checkpoint <= '0;
      end
    end
  end

endmodule
